// File: rtl/square_root_core.sv
// rtl/square_root_core.sv - iterative restoring integer square root, one root bit per cycle.
// Optional remainder output register enabled by macro SQRT_REMAINDER_EN.
module square_root_core #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   radicand,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH/2-1:0] root,
  output logic [DATA_WIDTH/2:0]   remainder
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam int RW   = HALF + 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  generate
    if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_bad_width
      $error("square_root_core: DATA_WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;

  state_t              state, state_next;
  logic [DATA_WIDTH-1:0] rad_q;
  logic [RW-1:0]       rem_q;
  logic [HALF-1:0]     q_q;
  logic [CW-1:0]       cnt;
  logic [HALF-1:0]     root_q;

  logic [RW+1:0]       r_shift;
  logic [RW+1:0]       trial;
  logic [RW+1:0]       rem_next;
  logic [HALF-1:0]     q_next;
  logic                last_step;
  logic                unused_bits;

  // Trial subtraction is two bits wider than the remainder so its sign is exact.
  always_comb begin
    r_shift = {rem_q, rad_q[DATA_WIDTH-1 -: 2]};
    trial   = r_shift - {2'b00, q_q, 2'b01};
    if (!trial[RW+1]) begin
      rem_next = trial;
      q_next   = {q_q[HALF-2:0], 1'b1};
    end else begin
      rem_next = r_shift;
      q_next   = {q_q[HALF-2:0], 1'b0};
    end
  end

  // The remainder never exceeds 2*Q, so the top two bits of rem_next are always zero.
  assign unused_bits = ^rem_next[RW+1:RW];
  assign last_step   = (state == ITERATE) && (cnt == '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ITERATE;
      ITERATE: if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      rad_q  <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      cnt    <= '0;
      root_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            rad_q <= radicand;
            rem_q <= '0;
            q_q   <= '0;
            cnt   <= CW'(HALF - 1);
          end
        end
        ITERATE: begin
          rad_q <= rad_q << 2;
          rem_q <= rem_next[RW-1:0];
          q_q   <= q_next;
          if (cnt == '0) begin
            root_q <= q_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SQRT_REMAINDER_EN
  logic [HALF:0] rem_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_out <= '0;
    end else if (last_step) begin
      rem_out <= rem_next[HALF:0];
    end
  end

  assign remainder = rem_out;
`else
  assign remainder = '0;
`endif

  assign busy = (state == ITERATE);
  assign done = (state == DONE);
  assign root = root_q;

endmodule

// File: tb/tb_square_root_core.sv
// tb/tb_square_root_core.sv - directed self-checking bench for square_root_core (DATA_WIDTH=16).
module tb_square_root_core;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] radicand;
  logic        busy;
  logic        done;
  logic [7:0]  root;
  logic [8:0]  remainder;

  int checks   = 0;
  int failures = 0;

  square_root_core #(.DATA_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .radicand  (radicand),
    .busy      (busy),
    .done      (done),
    .root      (root),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int exp_rem(input int full_rem);
`ifdef SQRT_REMAINDER_EN
    return full_rem;
`else
    return 0;
`endif
  endfunction

  // Launch one computation and follow it to done; radicand is scrambled after capture.
  task automatic run_op(input string tag, input logic [15:0] val, input int exp_root,
                        input int rem_full, input bit repulse, input bit hold_start);
    int  n;
    int  busy_cnt;
    bit  seen;
    @(negedge clk);
    start    = 1'b1;
    radicand = val;
    n        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start    = hold_start;
        radicand = ~val;
      end
      if (repulse && n == 3) begin
        start    = 1'b1;
        radicand = 16'd9;
      end
      if (repulse && n == 4) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    check_value({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_value({tag, "_latency"}, 32'(n), 32'd9);
    check_value({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check_value({tag, "_root"}, 32'(root), 32'(exp_root));
    check_value({tag, "_remainder"}, 32'(remainder), 32'(exp_rem(rem_full)));
  endtask

  task automatic check_quiet(input string tag, input int cycles, input int exp_root, input int rem_full);
    int extra_done;
    extra_done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      radicand = 16'(i * 977);
      if (done) extra_done++;
    end
    check_value({tag, "_no_extra_done"}, 32'(extra_done), 32'd0);
    check_value({tag, "_root_hold"}, 32'(root), 32'(exp_root));
    check_value({tag, "_rem_hold"}, 32'(remainder), 32'(exp_rem(rem_full)));
  endtask

  initial begin
    int seen_done;
    reset    = 1'b0;
    start    = 1'b1;
    radicand = 16'd144;
    repeat (3) @(negedge clk);
    check_value("reset_busy", 32'(busy), 32'd0);
    check_value("reset_done", 32'(done), 32'd0);
    check_value("reset_root", 32'(root), 32'd0);
    check_value("reset_rem", 32'(remainder), 32'd0);
    start = 1'b0;
    reset = 1'b1;

    run_op("zero", 16'd0, 0, 0, 1'b0, 1'b0);
    check_quiet("zero", 3, 0, 0);
    run_op("r144", 16'd144, 12, 0, 1'b0, 1'b0);
    run_op("r143", 16'd143, 11, 22, 1'b0, 1'b0);
    check_quiet("r143", 4, 11, 22);
    run_op("rmax", 16'd65535, 255, 510, 1'b0, 1'b0);
    run_op("rone", 16'd1, 1, 0, 1'b0, 1'b0);
    run_op("repulse", 16'd100, 10, 0, 1'b1, 1'b0);
    check_quiet("repulse", 12, 10, 0);

    // Back-to-back: start held through DONE is taken in the following IDLE cycle.
    run_op("b2b_a", 16'd143, 11, 22, 1'b0, 1'b1);
    radicand = 16'd144;
    @(negedge clk);
    check_value("b2b_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check_value("b2b_restart_busy", 32'(busy), 32'd1);
    seen_done = 0;
    for (int i = 0; i < 20 && seen_done == 0; i++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check_value("b2b_b_done", 32'(seen_done), 32'd1);
    check_value("b2b_b_root", 32'(root), 32'd12);
    check_value("b2b_b_rem", 32'(remainder), 32'(exp_rem(0)));

    // Abort at iteration 4 with one reset edge, with start asserted during reset.
    @(negedge clk);
    start    = 1'b1;
    radicand = 16'd50000;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_value("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    check_value("abort_busy", 32'(busy), 32'd0);
    check_value("abort_done", 32'(done), 32'd0);
    check_value("abort_root", 32'(root), 32'd0);
    check_value("abort_rem", 32'(remainder), 32'd0);
    check_quiet("abort", 12, 0, 0);
    check_value("abort_idle", 32'(busy), 32'd0);
    run_op("r50000", 16'd50000, 223, 271, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
